// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM states
// and the byte-enable helper used for stores.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, RESP} state_t;

  // Lane mask for an aligned access; callers gate it with the error checks.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << lo;
      F3_H, F3_HU: be = lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage (master) and the data-memory
// controller (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with per-byte write enables and a combinational read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I load/store controller: decodes and checks each request, writes byte
// lanes, extends load data and holds one registered response.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic   clk_dm,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  state_t      state, state_next;
  logic        accept;
  logic        f3_ok, misaligned, out_of_range, err;
  logic [1:0]  lo;
  logic [3:0]  be;
  logic [31:0] word, shifted, ext, load_data;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  assign lo     = bus.req_addr[1:0];
  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    f3_ok = 1'b0;
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !bus.req_we;
      default:          f3_ok = 1'b0;
    endcase
  end

  assign misaligned   = (bus.req_funct3[1:0] == 2'b01 && lo[0]) ||
                        (bus.req_funct3[1:0] == 2'b10 && lo != 2'b00);
  assign out_of_range = bus.req_addr >= ADDR_LIMIT;
  assign err          = !f3_ok || misaligned || out_of_range;

  assign be = (accept && bus.req_we && !err) ? byte_en(bus.req_funct3, lo) : 4'b0000;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk_dm),
    .addr  (bus.req_addr[AW+1:2]),
    .be    (be),
    .wdata (bus.req_wdata << {lo, 3'b000}),
    .rdata (word)
  );

  assign shifted = word >> {lo, 3'b000};

  always_comb begin
    ext = word;
    case (bus.req_funct3)
      F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ext = {24'h0, shifted[7:0]};
      F3_HU:   ext = {16'h0, shifted[15:0]};
      default: ext = word;
    endcase
  end

  assign load_data = (bus.req_we || err) ? 32'h0 : ext;

  always_ff @(posedge clk_dm or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Staying in RESP on a simultaneous drain+accept is what allows one response per cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RESP;
      RESP:    if (bus.rsp_ready && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_dm or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_rdata_q <= load_data;
      rsp_err_q   <= err;
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.req_ready = (state == IDLE) || bus.rsp_ready;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with hand-computed expectations.
module tb_dmem_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dmem_if bus ();

  dmem_ctrl #(.DEPTH(64)) dut (
    .clk_dm (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one request and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 10) checkOutput("accept_timeout", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic runReq(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    bus.rsp_ready = 1'b1;
    applyStimulus(we, f3, addr, wdata);
    checkOutput({tag, "_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
    checkOutput({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'h0, bus.rsp_err}, {31'h0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    checkOutput("rst_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("rst_err", {31'h0, bus.rsp_err}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_ready", {31'h0, bus.req_ready}, 32'h1);

    runReq("clr0",  1'b1, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0);
    runReq("clr20", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    runReq("clr30", 1'b1, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0);

    runReq("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    runReq("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    runReq("sb21",  1'b1, 3'b000, 32'h21, 32'h12345680, 32'h0, 1'b0);
    runReq("lb21",  1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
    runReq("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0);
    runReq("lw20",  1'b0, 3'b010, 32'h20, 32'h0, 32'h00008000, 1'b0);

    runReq("sh32",  1'b1, 3'b001, 32'h32, 32'h12348001, 32'h0, 1'b0);
    runReq("lh32",  1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF8001, 1'b0);
    runReq("lhu32", 1'b0, 3'b101, 32'h32, 32'h0, 32'h00008001, 1'b0);
    runReq("lh33",  1'b0, 3'b001, 32'h33, 32'h0, 32'h0, 1'b1);
    runReq("lw30",  1'b0, 3'b010, 32'h30, 32'h0, 32'h80010000, 1'b0);

    runReq("sw102", 1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 32'h0, 1'b1);
    runReq("sw100", 1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 32'h0, 1'b1);
    runReq("sw12",  1'b1, 3'b010, 32'h12, 32'hCAFEF00D, 32'h0, 1'b1);
    runReq("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    runReq("st_f3_100", 1'b1, 3'b100, 32'h10, 32'hCAFEF00D, 32'h0, 1'b1);
    runReq("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1);
    runReq("lw0_kept",  1'b0, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0);
    runReq("lw10_kept", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Backpressure: response must freeze while a second request waits.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checkOutput("hold_valid", {31'h0, bus.rsp_valid}, 32'h1);
      checkOutput("hold_ready", {31'h0, bus.req_ready}, 32'h0);
      checkOutput("hold_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("drain_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("next_valid", {31'h0, bus.rsp_valid}, 32'h1);
    checkOutput("next_rdata", bus.rsp_rdata, 32'h00008000);
    @(posedge clk); #1;
    checkOutput("drain_idle", {31'h0, bus.rsp_valid}, 32'h0);

    // Back-to-back: 8 stores then 8 loads, first load hits the last stored word.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp;
      if (i < 8) begin
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h40 + 32'(4 * i);
        bus.req_wdata = 32'h1000 + 32'(i);
        exp           = 32'h0;
      end else begin
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h5C - 32'(4 * (i - 8));
        bus.req_wdata = 32'h0;
        exp           = 32'h1000 + 32'(15 - i);
      end
      bus.req_funct3 = 3'b010;
      bus.req_valid  = 1'b1;
      checkOutput("stream_ready", {31'h0, bus.req_ready}, 32'h1);
      @(posedge clk); #1;
      checkOutput("stream_valid", {31'h0, bus.rsp_valid}, 32'h1);
      checkOutput("stream_rdata", bus.rsp_rdata, exp);
      checkOutput("stream_err", {31'h0, bus.rsp_err}, 32'h0);
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("stream_end", {31'h0, bus.rsp_valid}, 32'h0);

    // Reset while a response is pending drops it but keeps memory.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    checkOutput("pre_rst_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    checkOutput("mid_rst_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("mid_rst_err", {31'h0, bus.rsp_err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runReq("lw10_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    runReq("lw5c_after_rst", 1'b0, 3'b010, 32'h5C, 32'h0, 32'h00001007, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
